pcode_loader: RTL
=================

PCODE_LOADER -- requirements
Module: pcode_loader

Interface
REQ-001 SHALL have parameter PCODE_LEN, default 40920, number of code bytes per load (range 2..65535).
REQ-002 SHALL have port clk  in  1  system clock; all logic rising-edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port start  in  1  one-cycle request to begin a load.
REQ-005 SHALL have port abort  in  1  cancel a load in progress.
REQ-006 SHALL have port s_data  in  8  incoming code byte; bit0 = chip 0 … bit7 = chip 7.
REQ-007 SHALL have port s_valid  in  1  s_data valid.
REQ-008 SHALL have port s_ready  out  1  loader accepts a byte.
REQ-009 SHALL have port wr_en  out  1  code-memory write strobe.
REQ-010 SHALL have port wr_addr  out  16  code-memory write address.
REQ-011 SHALL have port wr_data  out  8  code-memory write byte.
REQ-012 SHALL have port busy  out  1  load in progress.
REQ-013 SHALL have port done  out  1  one-cycle pulse on successful load completion.
REQ-014 SHALL have port csum_err  out  1  sticky checksum mismatch flag.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, CHECK, DONE; all outputs registered.
REQ-016 IDLE: start=1 -> LOAD next cycle; internal index cleared to 0; csum_err cleared.
REQ-017 s_ready SHALL be 1 exactly in LOAD and CHECK; busy SHALL be 1 in LOAD, CHECK, DONE.
REQ-018 Byte accepted on cycle where s_valid && s_ready; unaccepted s_data ignored; s_valid may stall arbitrarily.
REQ-019 In LOAD, accepted byte SHALL produce wr_en=1, wr_addr=index, wr_data=byte on the following cycle (latency 1); wr_en=0 otherwise.
REQ-020 Index SHALL increment by 1 per accepted byte; the byte at index PCODE_LEN-1 ends LOAD (-> CHECK or DONE per REQ-030/031); no wrap past PCODE_LEN-1.
REQ-021 DONE SHALL last exactly one cycle with done=1, then -> IDLE.
REQ-022 start while busy SHALL be ignored.
REQ-023 abort in LOAD or CHECK SHALL -> IDLE next cycle, no done pulse, no write for a byte accepted in the same cycle (abort wins).
REQ-024 abort in IDLE or DONE SHALL be ignored; DONE completes normally.
REQ-025 Simultaneous start and abort in IDLE: start wins.

Reset
REQ-026 rst SHALL force state IDLE, index 0, running checksum 0.
REQ-027 rst SHALL force s_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, csum_err=0.
REQ-028 rst mid-load SHALL cancel without done and without a pending write on the next cycle.

Configuration
REQ-029 Macro PCODE_LOADER_CSUM_EN SHALL select checksum checking.
REQ-030 With PCODE_LOADER_CSUM_EN defined: running XOR of all accepted code bytes kept; after last code byte -> CHECK; one further accepted byte (not written) compared to XOR; match -> DONE; mismatch -> csum_err=1, -> IDLE, no done.
REQ-031 Without PCODE_LOADER_CSUM_EN: CHECK unreachable, last code byte -> DONE directly, csum_err constant 0.

Verification (PCODE_LEN=8 in sim)
REQ-032 rst; start; bytes 00..07 with s_valid held 1 -> wr_en 8 cycles, wr_addr 0..7, wr_data 00..07, done pulses once, busy=0 after.
REQ-033 Same stream, s_valid toggling 1/0 each cycle -> identical 8 writes, no duplicates, no gaps in address.
REQ-034 abort asserted with 4th accepted byte -> only addresses 0..2 written, no done, s_ready=0 next cycle, fresh start re-writes from addr 0.
REQ-035 CSUM_EN: bytes 01,02,04,08,10,20,40,80 then FF -> done=1, csum_err=0; same with trailer 00 -> csum_err=1, no done.
REQ-036 start pulsed during LOAD and rst asserted at index 5 -> no restart from start; after rst all outputs 0, state IDLE.

Source files
------------

// File: rtl/pcode_loader.sv
// pcode_loader: streams PCODE_LEN code bytes from a valid/ready source into
// code memory with one-cycle write latency. Define PCODE_LOADER_CSUM_EN to
// require a trailing XOR checksum byte before completion is reported.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting code bytes and writing them to memory
// CHECK | waiting for the checksum trailer byte (CSUM build only)
// DONE  | one-cycle completion pulse
module pcode_loader #(
  parameter int PCODE_LEN = 40920
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        done,
  output logic        csum_err
);

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;

  localparam logic [15:0] LAST_IDX = 16'(PCODE_LEN - 1);

  state_t      state, next_state;
  logic [15:0] index;
  logic        accept;
  logic        last_byte;

  // s_ready is only ever high in LOAD/CHECK, so accept implies one of those.
  assign accept    = s_valid && s_ready;
  assign last_byte = (index == LAST_IDX);

`ifdef PCODE_LOADER_CSUM_EN
  logic [7:0] csum;
  logic       csum_ok;
  assign csum_ok = (s_data == csum);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; abort only matters while a load is active
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start) next_state = LOAD;
      LOAD: begin
        if (abort) next_state = IDLE;
        else if (accept && last_byte) begin
`ifdef PCODE_LOADER_CSUM_EN
          next_state = CHECK;
`else
          next_state = DONE;
`endif
        end
      end
      CHECK: begin
`ifdef PCODE_LOADER_CSUM_EN
        if (abort)       next_state = IDLE;
        else if (accept) next_state = csum_ok ? DONE : IDLE;
`else
        next_state = IDLE;
`endif
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered outputs track the state being entered; write port lags acceptance by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      index    <= '0;
      s_ready  <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      csum_err <= 1'b0;
`ifdef PCODE_LOADER_CSUM_EN
      csum     <= '0;
`endif
    end else begin
      s_ready <= (next_state == LOAD) || (next_state == CHECK);
      busy    <= (next_state != IDLE);
      done    <= (next_state == DONE);
      wr_en   <= 1'b0;

      if (state == IDLE && start) begin
        index    <= '0;
        csum_err <= 1'b0;
`ifdef PCODE_LOADER_CSUM_EN
        csum     <= '0;
`endif
      end

      if (state == LOAD && accept && !abort) begin
        wr_en   <= 1'b1;
        wr_addr <= index;
        wr_data <= s_data;
        if (!last_byte) index <= index + 16'd1;
`ifdef PCODE_LOADER_CSUM_EN
        csum    <= csum ^ s_data;
`endif
      end

`ifdef PCODE_LOADER_CSUM_EN
      if (state == CHECK && accept && !abort && !csum_ok) csum_err <= 1'b1;
`endif
    end
  end

endmodule
